// File: rtl/shield_arb_pkg.sv
// Shared types, constants and grant encoding helpers for the shield accelerator arbiter.
package shield_arb_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef logic [ID_W-1:0] req_id_t;

  localparam logic [1:0] CHOOSE_IDLE = 2'b00;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
    case (id)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_choose(input logic [NUM_REQ-1:0] oh);
    case (oh)
      3'b001:  return 2'b01;
      3'b010:  return 2'b10;
      3'b100:  return 2'b11;
      default: return CHOOSE_IDLE;
    endcase
  endfunction

  function automatic logic [NUM_REQ-1:0] choose_to_onehot(input logic [1:0] choose);
    case (choose)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Successor in the 0 -> 1 -> 2 -> 0 ring.
  function automatic req_id_t next_id(input req_id_t id);
    case (id)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/shield_arb_rr_pick.sv
// Combinational round-robin picker: first requester with req high, scanning from rr_ptr+1.
module shield_arb_rr_pick
  import shield_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_ptr,
  output logic               valid_c,
  output req_id_t            id_c
);

  always_comb begin
    req_id_t cand;
    valid_c = 1'b0;
    id_c    = rr_ptr;
    cand    = next_id(rr_ptr);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_c && req[cand]) begin
        valid_c = 1'b1;
        id_c    = cand;
      end
      cand = next_id(cand);
    end
  end

endmodule

// File: rtl/shield_arbiter.sv
// Round-robin owner arbiter for the shield datapath with one-cycle turnaround and watchdog.
// Optional per-requester grant counters are enabled with SHIELD_ARB_STATS_EN.
module shield_arbiter
  import shield_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
`ifdef SHIELD_ARB_STATS_EN
  ,
  parameter int unsigned STAT_W         = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         choose,
  output logic               busy,
  output logic               timeout,
  output logic [1:0]         timeout_id
`ifdef SHIELD_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  grant_cnt0,
  output logic [STAT_W-1:0]  grant_cnt1,
  output logic [STAT_W-1:0]  grant_cnt2
`endif
);

  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  req_id_t              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 timeout_d;
  logic [1:0]           timeout_id_d;
  logic                 enter_own;
  logic                 pick_valid;
  req_id_t              pick_id;
  logic                 owner_done;

  shield_arb_rr_pick u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .valid_c (pick_valid),
    .id_c    (pick_id)
  );

  // In OWN the registered grant is onehot(owner), so masking done with it selects done[owner].
  assign owner_done = |(done & grant);
  assign choose     = onehot_to_choose(grant);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    grant_d      = grant;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id;
    enter_own    = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        grant_d = '0;
        if (pick_valid) begin
          state_d   = OWN;
          rr_ptr_d  = pick_id;
          cnt_d     = '0;
          grant_d   = id_to_onehot(pick_id);
          enter_own = 1'b1;
        end
      end
      OWN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (owner_done) begin
          state_d = GAP;
          grant_d = '0;
        end else if (WD_EN && (cnt_q == TO_LAST)) begin
          state_d      = GAP;
          grant_d      = '0;
          timeout_d    = 1'b1;
          timeout_id_d = onehot_to_choose(grant);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= req_id_t'(2);
      cnt_q      <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= CHOOSE_IDLE;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      grant      <= grant_d;
      busy       <= (state_d == OWN);
      timeout    <= timeout_d;
      timeout_id <= timeout_id_d;
    end
  end

`ifdef SHIELD_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;

  // Saturating count of ownership periods started per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_q[g] <= '0;
      end else if (enter_own && (pick_id == req_id_t'(g)) && !(&stat_q[g])) begin
        stat_q[g] <= stat_q[g] + STAT_W'(1);
      end
    end
  end

  assign grant_cnt0 = stat_q[0];
  assign grant_cnt1 = stat_q[1];
  assign grant_cnt2 = stat_q[2];
`endif

endmodule

// File: tb/tb_shield_arbiter.sv
// Scoreboard bench for shield_arbiter: driver pushes model expectations, monitor pops and compares.
module tb_shield_arbiter;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] done = 3'b000;
  logic [2:0] grant;
  logic [1:0] choose;
  logic       busy;
  logic       timeout;
  logic [1:0] timeout_id;
`ifdef SHIELD_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, grant_cnt2;
  int          m_stat [3] = '{0, 0, 0};
`endif

  always #5 clk = ~clk;

  shield_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .choose     (choose),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
`ifdef SHIELD_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .grant_cnt2 (grant_cnt2)
`endif
  );

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] choose;
    logic       busy;
    logic       timeout;
    logic [1:0] tid;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: current owner (-1 = nobody), last granted id, owned cycles so far.
  int m_owner = -1;
  int m_last  = 2;
  int m_cnt   = 0;
  int m_tid   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_cnt   = 0;
    m_tid   = 0;
  endtask

  // One clock edge of the specified behaviour with inputs r/d sampled; pushes the outputs that follow.
  task automatic model_step(input logic [2:0] r, input logic [2:0] d);
    exp_t e;
    bit   tmo;
    int   p;
    tmo = 1'b0;
    if (m_owner >= 0) begin
      m_cnt++;
      if (d[m_owner]) begin
        m_owner = -1;
      end else if (m_cnt == TO) begin
        m_tid   = m_owner + 1;
        tmo     = 1'b1;
        m_owner = -1;
      end
    end else begin
      p = m_pick(r);
      if (p >= 0) begin
        m_owner = p;
        m_last  = p;
        m_cnt   = 0;
`ifdef SHIELD_ARB_STATS_EN
        if (m_stat[p] < 65535) m_stat[p]++;
`endif
      end
    end
    e.grant   = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    e.choose  = 2'(m_owner + 1);
    e.busy    = (m_owner >= 0);
    e.timeout = tmo;
    e.tid     = 2'(m_tid);
    q.push_back(e);
  endtask

  task automatic cyc(input logic [2:0] r, input logic [2:0] d);
    @(negedge clk);
    req  = r;
    done = d;
    model_step(r, d);
  endtask

  function automatic logic [2:0] own_oh();
    return (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant",      32'(grant),      32'(e.grant));
        chk("choose",     32'(choose),     32'(e.choose));
        chk("busy",       32'(busy),       32'(e.busy));
        chk("timeout",    32'(timeout),    32'(e.timeout));
        chk("timeout_id", 32'(timeout_id), 32'(e.tid));
      end
    end
  end

  initial begin : driver
    repeat (3) @(negedge clk);
    chk("rst_grant",   32'(grant),      32'd0);
    chk("rst_choose",  32'(choose),     32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_timeout", 32'(timeout),    32'd0);
    chk("rst_tid",     32'(timeout_id), 32'd0);
    rst_n = 1'b1;

    // Single requester, done on owner, then idle.
    repeat (4) cyc(3'b001, 3'b000);
    cyc(3'b001, 3'b001);
    repeat (3) cyc(3'b000, 3'b000);

    // All requesting; each owner finishes three cycles after its grant.
    repeat (40) cyc(3'b111, (m_owner >= 0 && m_cnt == 2) ? own_oh() : 3'b000);
    repeat (3) cyc(3'b000, own_oh());

    // Owner 1 ignores foreign done and its own req drop.
    repeat (2) cyc(3'b010, 3'b000);
    repeat (5) cyc(3'b000, 3'b101);
    cyc(3'b000, 3'b010);
    repeat (2) cyc(3'b000, 3'b000);

    // Hung owner 2 hits the watchdog.
    repeat (12) cyc(3'b100, 3'b000);
    cyc(3'b000, 3'b100);
    repeat (2) cyc(3'b000, 3'b000);

    // done coinciding with the last watchdog cycle wins.
    repeat (10) cyc(3'b100, (m_owner == 2 && m_cnt == TO - 1) ? 3'b100 : 3'b000);
    cyc(3'b000, 3'b100);
    repeat (2) cyc(3'b000, 3'b000);

    // Asynchronous reset in the middle of an ownership period.
    repeat (2) cyc(3'b001, 3'b000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_grant",  32'(grant),  32'd0);
    chk("async_choose", 32'(choose), 32'd0);
    chk("async_busy",   32'(busy),   32'd0);
    req  = 3'b000;
    done = 3'b000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(3'b110, 3'b000);
    cyc(3'b000, own_oh());
    repeat (2) cyc(3'b000, 3'b000);

    // Random traffic with sparse done pulses so watchdog expiries also occur.
    repeat (3000) cyc(3'($urandom_range(0, 7)), 3'($urandom) & 3'($urandom));

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef SHIELD_ARB_STATS_EN
    chk("grant_cnt0", 32'(grant_cnt0), 32'(m_stat[0]));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(m_stat[1]));
    chk("grant_cnt2", 32'(grant_cnt2), 32'(m_stat[2]));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
